// File: rtl/mem_frame_pkg.sv
// Shared types and constants for the memory frame writer.
// Record layout: {weights[79:0], data[31:0]}, 14 payload bytes.
package mem_frame_pkg;

  localparam logic [7:0]  HDR_BYTE      = 8'hA5;
  localparam int unsigned WEIGHT_W      = 80;
  localparam int unsigned DATA_W        = 32;
  localparam int unsigned REC_W         = WEIGHT_W + DATA_W;
  localparam int unsigned PAYLOAD_BYTES = REC_W / 8;
  localparam int unsigned IDX_W         = $clog2(PAYLOAD_BYTES);

  typedef struct packed {
    logic [WEIGHT_W-1:0] weight;
    logic [DATA_W-1:0]   data;
  } rec_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PAYLOAD,
    ST_CHECK,
    ST_OUTPUT
  } state_e;

endpackage

// File: rtl/mem_frame_writer_if.sv
// Byte-stream input, record handshake and status counters of the frame writer.
interface mem_frame_writer_if
  import mem_frame_pkg::*;
  ;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  rec_t        rec_out;
  logic        rec_valid;
  logic        rec_ready;
  logic [15:0] frame_cnt;
  logic [7:0]  err_cnt;
  logic        err_pulse;

  modport master (
    output in_data, in_valid, rec_ready,
    input  in_ready, rec_out, rec_valid, frame_cnt, err_cnt, err_pulse
  );

  modport slave (
    input  in_data, in_valid, rec_ready,
    output in_ready, rec_out, rec_valid, frame_cnt, err_cnt, err_pulse
  );
endinterface

// File: rtl/frame_xor_acc.sv
// 8-bit running XOR of payload bytes; clear has priority over enable.
module frame_xor_acc (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [7:0] data_i,
  output logic [7:0] acc_o
);

  logic [7:0] acc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     acc_q <= 8'h00;
    else if (clr_i) acc_q <= 8'h00;
    else if (en_i)  acc_q <= acc_q ^ data_i;
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/mem_frame_writer.sv
// Hunts HDR_BYTE, shifts 14 payload bytes MSB-first into a record, hands it out.
// MEM_FRAME_CHECKSUM_EN adds a trailing XOR checksum byte with error counting.
module mem_frame_writer
  import mem_frame_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  mem_frame_writer_if.slave  bus
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  rec_t               rec_q, rec_d;
  logic               rec_valid_q;
  logic               in_ready_q;
  logic [15:0]        frame_cnt_q, frame_cnt_d;
  logic               accept;

  assign accept = bus.in_valid & in_ready_q;

`ifdef MEM_FRAME_CHECKSUM_EN
  logic [7:0] err_cnt_q, err_cnt_d;
  logic       err_pulse_q, err_pulse_d;
  logic       acc_clr, acc_en;
  logic [7:0] acc;

  frame_xor_acc u_xor_acc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (acc_clr),
    .en_i   (acc_en),
    .data_i (bus.in_data),
    .acc_o  (acc)
  );
`endif

  // Next-state, record shift and counter updates
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rec_d       = rec_q;
    frame_cnt_d = frame_cnt_q;
`ifdef MEM_FRAME_CHECKSUM_EN
    err_cnt_d   = err_cnt_q;
    err_pulse_d = 1'b0;
    acc_clr     = 1'b0;
    acc_en      = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept && bus.in_data == HDR_BYTE) begin
          state_d = ST_PAYLOAD;
          idx_d   = '0;
`ifdef MEM_FRAME_CHECKSUM_EN
          acc_clr = 1'b1;
`endif
        end
      end
      ST_PAYLOAD: begin
        if (accept) begin
          rec_d = rec_t'({rec_q[REC_W-9:0], bus.in_data});
`ifdef MEM_FRAME_CHECKSUM_EN
          acc_en = 1'b1;
`endif
          if (idx_q == IDX_W'(PAYLOAD_BYTES - 1)) begin
`ifdef MEM_FRAME_CHECKSUM_EN
            state_d = ST_CHECK;
`else
            state_d = ST_OUTPUT;
`endif
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
`ifdef MEM_FRAME_CHECKSUM_EN
      ST_CHECK: begin
        if (accept) begin
          if (bus.in_data == acc) begin
            state_d = ST_OUTPUT;
          end else begin
            state_d     = ST_IDLE;
            err_pulse_d = 1'b1;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
          end
        end
      end
`endif
      ST_OUTPUT: begin
        if (bus.rec_ready) begin
          state_d     = ST_IDLE;
          frame_cnt_d = frame_cnt_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      rec_q       <= '0;
      rec_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rec_q       <= rec_d;
      rec_valid_q <= (state_d == ST_OUTPUT);
      in_ready_q  <= (state_d != ST_OUTPUT);
      frame_cnt_q <= frame_cnt_d;
    end
  end

`ifdef MEM_FRAME_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q   <= 8'h00;
      err_pulse_q <= 1'b0;
    end else begin
      err_cnt_q   <= err_cnt_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  assign bus.err_cnt   = err_cnt_q;
  assign bus.err_pulse = err_pulse_q;
`else
  assign bus.err_cnt   = 8'h00;
  assign bus.err_pulse = 1'b0;
`endif

  assign bus.in_ready  = in_ready_q;
  assign bus.rec_out   = rec_q;
  assign bus.rec_valid = rec_valid_q;
  assign bus.frame_cnt = frame_cnt_q;

endmodule
